// File: rtl/line_mem_pkg.sv
// Shared widths and types for the single-line video buffer.
package line_mem_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 10;
  localparam int LINE_LEN = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_MAX = addr_t'(LINE_LEN - 1);

endpackage

// File: rtl/line_mem_ram.sv
// Single-port, read-first line RAM with a registered read port.
// The array has no reset; contents survive rstx.
module line_mem_ram
  import line_mem_pkg::*;
(
  input  logic   clk_i,
  input  logic   en_i,
  input  logic   we_i,
  input  addr_t  addr_i,
  input  pixel_t wdata_i,
  output pixel_t rdata_o
);

  pixel_t mem_q [LINE_LEN];
  pixel_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_mem.sv
// Line buffer: emits the current pixel (qa) and the pixel one line above
// (qb) with hd/de delayed to match, fixed 2-cycle latency.
module line_mem
  import line_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rstx,
  input  logic   hd,
  input  logic   de,
  input  pixel_t d,
  output logic   hdo,
  output logic   deo,
  output pixel_t qa,
  output pixel_t qb
);

  logic   hd_d1_q;
  addr_t  addr_q, addr_d;
  logic   full_q, full_d;
  logic   seen_q, seen_d;
  logic   pv_q, pv_d;

  logic   de1_q;
  pixel_t d1_q;
  logic   qb_ok1_q;

  logic   hdo_q, deo_q;
  pixel_t qa_q, qb_q;

  logic   hd_rise;
  addr_t  addr_cur;
  logic   ovf_now;
  logic   pv_now;
  logic   wr_en;
  pixel_t rdata;

  // A pixel arriving on the hd edge already belongs to the new line.
  assign hd_rise  = hd & ~hd_d1_q;
  assign addr_cur = hd_rise ? '0 : addr_q;
  assign ovf_now  = hd_rise ? 1'b0 : full_q;
  assign pv_now   = hd_rise ? seen_q : pv_q;
  assign wr_en    = de & ~ovf_now;

  always_comb begin
    addr_d = addr_cur;
    if (wr_en && (addr_cur != ADDR_MAX)) begin
      addr_d = addr_cur + 1'b1;
    end
    full_d = ovf_now | (wr_en & (addr_cur == ADDR_MAX));
    seen_d = hd_rise ? de : (seen_q | de);
    pv_d   = pv_now;
  end

  always_ff @(posedge clk or posedge rstx) begin
    if (rstx) begin
      hd_d1_q <= 1'b0;
      addr_q  <= '0;
      full_q  <= 1'b0;
      seen_q  <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      hd_d1_q <= hd;
      addr_q  <= addr_d;
      full_q  <= full_d;
      seen_q  <= seen_d;
      pv_q    <= pv_d;
    end
  end

  line_mem_ram u_ram (
    .clk_i   (clk),
    .en_i    (de),
    .we_i    (wr_en),
    .addr_i  (addr_cur),
    .wdata_i (d),
    .rdata_o (rdata)
  );

  // Stage 1 runs alongside the RAM read; stage 2 drives the outputs.
  always_ff @(posedge clk or posedge rstx) begin
    if (rstx) begin
      de1_q    <= 1'b0;
      d1_q     <= '0;
      qb_ok1_q <= 1'b0;
      hdo_q    <= 1'b0;
      deo_q    <= 1'b0;
      qa_q     <= '0;
      qb_q     <= '0;
    end else begin
      de1_q    <= de;
      d1_q     <= de ? d : '0;
      qb_ok1_q <= wr_en & pv_now;
      hdo_q    <= hd_d1_q;
      deo_q    <= de1_q;
      qa_q     <= de1_q ? d1_q : '0;
      qb_q     <= qb_ok1_q ? rdata : '0;
    end
  end

  assign hdo = hdo_q;
  assign deo = deo_q;
  assign qa  = qa_q;
  assign qb  = qb_q;

endmodule

// File: tb/tb_line_mem.sv
// Randomized bench for line_mem against a per-column line model.
module tb_line_mem;
  import line_mem_pkg::*;

  logic   clk = 1'b0;
  logic   rstx;
  logic   hd, de;
  pixel_t d;
  logic   hdo, deo;
  pixel_t qa, qb;

  line_mem dut (
    .clk  (clk),
    .rstx (rstx),
    .hd   (hd),
    .de   (de),
    .d    (d),
    .hdo  (hdo),
    .deo  (deo),
    .qa   (qa),
    .qb   (qb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic   hdo;
    logic   deo;
    pixel_t qa;
    pixel_t qb;
    logic   care_qb;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference: remembered line contents per column plus line bookkeeping.
  pixel_t ref_line [LINE_LEN];
  bit     ref_written [LINE_LEN];
  bit     m_hd_prev;
  bit     m_pv;
  bit     m_seen;
  int     m_col;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hd_prev = 1'b0;
    m_pv      = 1'b0;
    m_seen    = 1'b0;
    m_col     = 0;
  endtask

  function automatic exp_t model_step(input bit h, input bit e, input pixel_t x);
    exp_t r;
    r.hdo = h; r.deo = e; r.qa = e ? x : '0; r.qb = '0; r.care_qb = 1'b1;
    if (h && !m_hd_prev) begin
      m_pv   = m_seen;
      m_seen = 1'b0;
      m_col  = 0;
    end
    if (e) begin
      m_seen = 1'b1;
      if (m_col < LINE_LEN) begin
        if (m_pv) begin
          r.qb      = ref_line[m_col];
          r.care_qb = ref_written[m_col];
        end
        ref_line[m_col]    = x;
        ref_written[m_col] = 1'b1;
      end
      m_col++;
    end
    m_hd_prev = h;
    return r;
  endfunction

  task automatic step(input bit h, input bit e, input pixel_t x);
    exp_t ex;
    hd = h; de = e; d = e ? x : pixel_t'($urandom);
    exp_q.push_back(model_step(h, e, x));
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) begin
      ex = exp_q.pop_front();
      chk("hdo", int'(hdo), int'(ex.hdo));
      chk("deo", int'(deo), int'(ex.deo));
      chk("qa",  int'(qa),  int'(ex.qa));
      if (ex.care_qb) chk("qb", int'(qb), int'(ex.qb));
    end
  endtask

  // mode 0: column ramp, 1: constant value, 2: random
  task automatic send_line(input int len, input int mode, input pixel_t val,
                           input int hd_w, input bit de_on_hd, input bit gaps);
    int col;
    col = 0;
    if (de_on_hd) begin
      step(1'b1, 1'b1, (mode == 0) ? pixel_t'(0) : (mode == 1) ? val : pixel_t'($urandom));
      col = 1;
      for (int i = 1; i < hd_w; i++) step(1'b1, 1'b0, '0);
    end else begin
      for (int i = 0; i < hd_w; i++) step(1'b1, 1'b0, '0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    end
    while (col < len) begin
      if (gaps && ($urandom_range(0, 7) == 0)) begin
        step(1'b0, 1'b0, '0);
      end else begin
        step(1'b0, 1'b1, (mode == 0) ? pixel_t'(col) : (mode == 1) ? val : pixel_t'($urandom));
        col++;
      end
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_hdo"}, int'(hdo), 0);
    chk({tag, "_deo"}, int'(deo), 0);
    chk({tag, "_qa"},  int'(qa),  0);
    chk({tag, "_qb"},  int'(qb),  0);
  endtask

  initial begin
    for (int i = 0; i < LINE_LEN; i++) begin
      ref_line[i]    = '0;
      ref_written[i] = 1'b0;
    end
    model_reset();
    rstx = 1'b1; hd = 1'b0; de = 1'b0; d = '0;
    for (int i = 0; i < 100; i++) @(posedge clk);
    #1;
    check_zero_outputs("rst_idle");
    rstx = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0);

    // Horizontal ramp: line 0 has no predecessor, then qb tracks qa.
    for (int n = 0; n < 3; n++) send_line(640, 0, '0, 2, 1'b0, 1'b0);

    // Vertical ramp: qb is one line value behind qa.
    for (int n = 0; n < 4; n++) send_line(640, 1, pixel_t'(n), 1, 1'b0, 1'b0);

    // Short line with single-cycle hd for edge alignment.
    send_line(16, 2, '0, 1, 1'b0, 1'b0);

    // Overflow: columns past the line capacity are neither stored nor read.
    send_line(1100, 2, '0, 1, 1'b0, 1'b0);
    send_line(1100, 2, '0, 1, 1'b0, 1'b0);

    // Reset in the middle of a line.
    send_line(500, 2, '0, 1, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, pixel_t'($urandom));
    hd = 1'b0; de = 1'b0;
    rstx = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    exp_q.delete();
    model_reset();
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    rstx = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    send_line(500, 2, '0, 1, 1'b0, 1'b0);
    send_line(500, 2, '0, 1, 1'b0, 1'b0);

    // Random lines: varying length, hd width, de gaps, pixel on the hd edge.
    for (int n = 0; n < 20; n++) begin
      send_line($urandom_range(1, 1150), 2, '0, $urandom_range(1, 3),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/line_mem.md
Name: line_mem

Overview:
- Single-line buffer (line memory) for a raster video stream driven by the signal generator.
- Stores each active line and outputs, per pixel, the current-line sample (qa) and the sample at the same horizontal position on the previous line (qb).
- Sync/enable (hdo/deo) are delayed to stay aligned with the data.
- Sits between the signal generator and any vertical filter or 2-tap processing stage.

Parameters:
- DATA_W, 8, pixel data width.
- ADDR_W, 10, line-buffer address width; line capacity 2**ADDR_W = 1024 pixels.

Ports:
- clk  in  1  system clock (100 MHz nominal); all logic rising-edge.
- rstx  in  1  asynchronous, active-high reset (port name kept from the codebase; asserted = 1).
- hd  in  1  horizontal sync; one or more cycles high at the start of each line.
- de  in  1  data enable; high for each active pixel.
- d  in  DATA_W  input pixel.
- hdo  out  1  hd delayed by 2 cycles.
- deo  out  1  de delayed by 2 cycles.
- qa  out  DATA_W  current-line pixel (d delayed 2 cycles).
- qb  out  DATA_W  previous-line pixel at the same column, aligned with qa.

Behaviour:
- Reset: hdo=0, deo=0, qa=0, qb=0, write address=0, prev_valid=0. RAM contents are not reset.
- Latency: fixed 2 clocks from inputs (hd, de, d) to outputs (hdo, deo, qa, qb). No handshake or back-pressure.
- Column counter:
  - Cleared to 0 on the rising edge of hd (hd=1 while hd_d1=0).
  - Otherwise increments by 1 in each cycle with de=1.
  - Saturates at 2**ADDR_W-1.
  - If de and the hd rising edge occur in the same cycle, the pixel uses address 0 and the counter becomes 1.
- RAM, single port, read-first:
  - In each cycle with de=1, the stored word at the current address is read and d is written to the same address.
  - The read returns the old (previous-line) value, registered once (cycle 1).
  - That value is registered a second time into qb (cycle 2).
- Overflow: once the counter has saturated, further de pixels in the same line are not written. Their qb is 0; qa and deo still pass through.
- prev_valid:
  - Set at the hd rising edge if at least one de pixel was seen since the previous hd edge (or since reset).
  - While prev_valid=0, qb is forced to 0, so the first line after reset outputs qb=0.
- When deo=0, qa=0 and qb=0; data is zeroed outside the active region.
- Reset asserted mid-line: all outputs go to 0 immediately (asynchronous). After release, behaviour is identical to a fresh start: the next line's qb=0, and the line after that sees valid data.
- Lines shorter than the previous line: only columns written in the current line are refreshed. Columns beyond the shorter line keep stale data, which only matters if a later line is longer.

Decomposition:
- Package line_mem_pkg holds DATA_W, ADDR_W and the pixel typedef (logic [DATA_W-1:0]).
- One sub-module, line_mem_ram: single-port, read-first, registered-output RAM of 2**ADDR_W x DATA_W with no reset on the array.
- Top level contains the counter, hd edge detect, prev_valid flag and 2-stage delay pipeline.

Test Plan:
- Reset then idle: rstx=1 for 100 cycles, release, no de -> hdo, deo, qa, qb remain 0.
- Horizontal ramp (d = column index, 0..639 mod 256) for 3 lines, hd pulse before each -> qa equals d 2 cycles later. Line 0: qb=0. Lines 1 and 2: qb==qa for every pixel.
- Vertical ramp (d = line number n for the whole line n) for 4 lines -> line 0: qb=0. Line n≥1: qa=n and qb=n-1 for all pixels.
- Alignment: hd high 1 cycle and de high for 16 pixels -> hdo and deo edges exactly 2 cycles after hd and de. deo high for exactly 16 cycles.
- Overflow: 1100 de pixels in one line, then a second line -> the second line's qb matches the first line for columns 0..1023 and is 0 for columns 1024..1099. No counter wrap.
- Reset mid-line: assert rstx during line 2 for 5 cycles -> outputs go to 0 in the same cycle. The next line after release has qb=0, and the line after that has correct qb.
